// File: rtl/main_fsm_pkg.sv
// Shared state codes, opcodes and control encodings
// for the multicycle RISC-V main control FSM.
package main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/main_fsm_outdec.sv
// Combinational control-word decode from current state
// and memory-ready; strobes in wait states gated by rdy.
module main_fsm_outdec
    import main_fsm_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       rdy,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_update,
    output logic       branch,
    output logic       reg_write,
    output logic       mem_write
);

    // Per-state control word; unreachable codes drive all zeros
    always_comb begin
        alu_op     = ALUOP_ADD;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        case (state_t'(state_i))
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                ir_write   = rdy;
                pc_update  = rdy;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = rdy;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V main control FSM: state register,
// next-state logic and reset gating of the control word.
module main_fsm
    import main_fsm_pkg::*;
#(
    parameter bit HAS_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   rdy;

    logic [1:0] dec_alu_op, dec_src_a, dec_src_b, dec_res;
    logic       dec_adr, dec_irw, dec_pcu, dec_br, dec_rw, dec_mw;

    assign rdy = HAS_MEM_READY ? mem_ready : 1'b1;

    // Next-state selection; op only matters in DECODE and MEMADR
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECUTER;
                    OP_ITYPE:  state_d = S_EXECUTEI;
                    OP_BRANCH: state_d = S_BEQ;
                    OP_JAL:    state_d = S_JAL;
                    default:   state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = rdy ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
        illegal_d = illegal_q | (state_d == S_ILLEGAL);
    end

    // State and sticky trap flag; reset aborts any instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    main_fsm_outdec u_outdec (
        .state_i    (state_q),
        .rdy        (rdy),
        .alu_op     (dec_alu_op),
        .alu_src_a  (dec_src_a),
        .alu_src_b  (dec_src_b),
        .result_src (dec_res),
        .adr_src    (dec_adr),
        .ir_write   (dec_irw),
        .pc_update  (dec_pcu),
        .branch     (dec_br),
        .reg_write  (dec_rw),
        .mem_write  (dec_mw)
    );

    assign ALUOp     = reset ? 2'b00 : dec_alu_op;
    assign ALUSrcA   = reset ? 2'b00 : dec_src_a;
    assign ALUSrcB   = reset ? 2'b00 : dec_src_b;
    assign ResultSrc = reset ? 2'b00 : dec_res;
    assign AdrSrc    = reset ? 1'b0  : dec_adr;
    assign IRWrite   = reset ? 1'b0  : dec_irw;
    assign PCUpdate  = reset ? 1'b0  : dec_pcu;
    assign Branch    = reset ? 1'b0  : dec_br;
    assign RegWrite  = reset ? 1'b0  : dec_rw;
    assign MemWrite  = reset ? 1'b0  : dec_mw;
    assign illegal   = illegal_q;
    assign state     = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Directed-vector bench for the multicycle main control FSM.
// Expected values hand-derived from the state/output table.
module tb_main_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       mem_ready;
    logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc, IRWrite, PCUpdate, Branch;
    logic       RegWrite, MemWrite, illegal;
    logic [3:0] state;

    int checks;
    int failures;

    main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .mem_ready (mem_ready),
        .ALUOp     (ALUOp),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .PCUpdate  (PCUpdate),
        .Branch    (Branch),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .illegal   (illegal),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        op        = 7'b0;
        mem_ready = 1'b1;

        // reset held two cycles; strobes forced low meanwhile
        tick();
        check("rst_irw", IRWrite, 0);
        check("rst_srcb", ALUSrcB, 0);
        tick();
        reset = 1'b0;
        #1;
        check("rel_state", state, 0);
        check("rel_irw", IRWrite, 1);
        check("rel_pcu", PCUpdate, 1);
        check("rel_rw", RegWrite, 0);
        check("rel_mw", MemWrite, 0);
        check("rel_br", Branch, 0);
        check("rel_ill", illegal, 0);
        check("rel_srcb", ALUSrcB, 2);
        check("rel_res", ResultSrc, 2);

        // R-type: 0,1,6,8,0; op change in EXECUTER ignored
        op = 7'b0110011;
        tick();
        check("r_s1", state, 1);
        check("r_srca1", ALUSrcA, 1);
        check("r_srcb1", ALUSrcB, 1);
        tick();
        check("r_s6", state, 6);
        check("r_aluop6", ALUOp, 2);
        check("r_rw6", RegWrite, 0);
        check("r_srca6", ALUSrcA, 2);
        op = 7'b1100011;
        tick();
        check("r_s8", state, 8);
        check("r_rw8", RegWrite, 1);
        tick();
        check("r_s0", state, 0);
        check("r_rw0", RegWrite, 0);

        // lw with 3 stall cycles in MEMREAD
        op = 7'b0000011;
        tick();
        check("lw_s1", state, 1);
        tick();
        check("lw_s2", state, 2);
        check("lw_srca2", ALUSrcA, 2);
        tick();
        mem_ready = 1'b0;
        #1;
        check("lw_s3a", state, 3);
        check("lw_adr_a", AdrSrc, 1);
        tick();
        check("lw_s3b", state, 3);
        check("lw_adr_b", AdrSrc, 1);
        tick();
        check("lw_s3c", state, 3);
        check("lw_adr_c", AdrSrc, 1);
        tick();
        mem_ready = 1'b1;
        #1;
        check("lw_s3d", state, 3);
        check("lw_adr_d", AdrSrc, 1);
        tick();
        check("lw_s4", state, 4);
        check("lw_res4", ResultSrc, 1);
        check("lw_rw4", RegWrite, 1);
        tick();
        check("lw_s0", state, 0);

        // sw with 2 stall cycles in MEMWRITE
        op = 7'b0100011;
        tick();
        tick();
        check("sw_s2", state, 2);
        tick();
        mem_ready = 1'b0;
        #1;
        check("sw_s5a", state, 5);
        check("sw_mw_a", MemWrite, 0);
        check("sw_adr_a", AdrSrc, 1);
        tick();
        check("sw_s5b", state, 5);
        check("sw_mw_b", MemWrite, 0);
        tick();
        mem_ready = 1'b1;
        #1;
        check("sw_s5c", state, 5);
        check("sw_mw_c", MemWrite, 1);
        tick();
        check("sw_s0", state, 0);
        check("sw_mw0", MemWrite, 0);

        // beq: 0,1,9,0
        op = 7'b1100011;
        tick();
        check("beq_s1", state, 1);
        tick();
        check("beq_s9", state, 9);
        check("beq_aluop", ALUOp, 1);
        check("beq_br", Branch, 1);
        tick();
        check("beq_s0", state, 0);
        check("beq_br0", Branch, 0);

        // jal: 0,1,10,8,0
        op = 7'b1101111;
        tick();
        tick();
        check("jal_s10", state, 10);
        check("jal_pcu", PCUpdate, 1);
        check("jal_srca", ALUSrcA, 1);
        check("jal_srcb", ALUSrcB, 2);
        tick();
        check("jal_s8", state, 8);
        check("jal_rw8", RegWrite, 1);
        tick();
        check("jal_s0", state, 0);

        // I-type: 0,1,7,8,0
        op = 7'b0010011;
        tick();
        tick();
        check("i_s7", state, 7);
        check("i_srcb", ALUSrcB, 1);
        check("i_aluop", ALUOp, 2);
        tick();
        check("i_s8", state, 8);
        tick();
        check("i_s0", state, 0);

        // illegal opcode traps and holds
        op = 7'b0000000;
        tick();
        tick();
        check("ill_s11", state, 11);
        check("ill_flag", illegal, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("ill_hold_s", state, 11);
            check("ill_hold_f", illegal, 1);
            check("ill_pcu", PCUpdate, 0);
        end

        // reset while in ILLEGAL
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("ill_rst_s", state, 0);
        check("ill_rst_f", illegal, 0);

        // reset mid-MEMREAD with memory stalled
        op = 7'b0000011;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        check("mr_s3", state, 3);
        reset = 1'b1;
        #1;
        check("mr_rst_adr", AdrSrc, 0);
        tick();
        reset     = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("mr_rst_s", state, 0);
        check("mr_rst_irw", IRWrite, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
